spi_burst_master: RTL and testbench

Parametrised SPI master that runs one register transaction per request: an address phase, then a variable-length data phase of 0..MAX_BYTES bytes. It supports all four CPOL/CPHA modes, a programmable SCLK divider and multiple chip selects. SCLK is generated as a registered signal, not gated from clk. It sits between the control-board register/command logic and the off-board SPI slaves, and returns the full-duplex read data with a done pulse.

---
 rtl/spi_burst_master.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_burst_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_master.sv
// SPI master running one address + 0..MAX_BYTES data-byte transaction per request.
// Supports CPOL/CPHA modes, a programmable half-period divider and multiple chip selects.
//
//   state   | meaning
//   S_IDLE  | sclk follows cpol, waiting for start
//   S_SETUP | chip select low, one half-period before the first edge
//   S_SHIFT | 2N half-periods of sclk toggling, shifting mosi/miso
//   S_HOLD  | sclk at idle level, chip select still low for one half-period
//   S_DONE  | one-cycle done pulse, rdata published
`timescale 1ns/1ps
module spi_burst_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BYTES  = 4,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8,
    localparam int DW  = 8 * MAX_BYTES,
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int NBW = $clog2(MAX_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CSW-1:0]        cs_sel,
    input  logic [NBW-1:0]        num_bytes,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DW-1:0]         wdata,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_CS-1:0]     cs_n,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TXW = ADDR_WIDTH + DW;
    localparam int BCW = $clog2(TXW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_cnt_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [BCW-1:0]        data_bits_q;
    logic                  phase_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic [TXW-1:0]        tx_q;
    logic [DW-1:0]         rx_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic [NUM_CS-1:0]     cs_n_q;
    logic [DW-1:0]         rdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [NBW-1:0]        nb_d;
    logic [BCW-1:0]        data_bits_d;
    logic [DW-1:0]         wdata_al_d;
    logic [TXW-1:0]        tx_d;
    logic                  cs_bad;
    logic                  boundary;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  drive_edge;
    logic                  in_data;

    // Data is left-justified behind the address so the shifter only ever moves MSB-first.
    always_comb begin
        nb_d = num_bytes;
        if (32'(num_bytes) > MAX_BYTES) begin
            nb_d = NBW'(MAX_BYTES);
        end
        data_bits_d = BCW'(nb_d) << 3;
        wdata_al_d  = wdata << (DW - 8 * int'(nb_d));
        tx_d        = {addr, wdata_al_d};
        cs_bad      = 32'(cs_sel) >= NUM_CS;
    end

    assign boundary    = (div_cnt_q == '0);
    assign lead_edge   = boundary && ((state_q == S_SETUP) ||
                         (state_q == S_SHIFT && !phase_q && bit_cnt_q != '0));
    assign trail_edge  = boundary && (state_q == S_SHIFT) && phase_q;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge : trail_edge;
    assign in_data     = (bit_cnt_q <= data_bits_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            data_bits_q <= '0;
            phase_q     <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= '1;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q != S_IDLE) begin
                div_cnt_q <= boundary ? div_q : div_cnt_q - DIV_WIDTH'(1);
            end
            if (lead_edge || trail_edge) begin
                sclk_q <= ~sclk_q;
            end
            if (sample_edge && in_data) begin
                rx_q <= {rx_q[DW-2:0], miso};
            end
            if (drive_edge) begin
                mosi_q <= tx_q[TXW-1];
                tx_q   <= tx_q << 1;
            end
            if (lead_edge) begin
                phase_q <= 1'b1;
            end
            if (trail_edge) begin
                phase_q   <= 1'b0;
                bit_cnt_q <= bit_cnt_q - BCW'(1);
            end

            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                cs_n_q  <= '1;
                sclk_q  <= cpol_q;
                mosi_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sclk_q <= cpol;
                        cpol_q <= cpol;
                        mosi_q <= 1'b0;
                        if (start) begin
                            if (cs_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                state_q     <= S_SETUP;
                                busy_q      <= 1'b1;
                                cs_n_q      <= ~(NUM_CS'(1) << cs_sel);
                                cpha_q      <= cpha;
                                div_q       <= clk_div;
                                div_cnt_q   <= clk_div;
                                data_bits_q <= data_bits_d;
                                bit_cnt_q   <= BCW'(ADDR_WIDTH) + data_bits_d;
                                phase_q     <= 1'b0;
                                rx_q        <= '0;
                                // cpha=0 needs the first bit valid before the first (sampling) edge.
                                if (!cpha) begin
                                    mosi_q <= tx_d[TXW-1];
                                    tx_q   <= tx_d << 1;
                                end else begin
                                    tx_q   <= tx_d;
                                end
                            end
                        end
                    end
                    S_SETUP: begin
                        if (boundary) begin
                            state_q <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (boundary && !phase_q && bit_cnt_q == '0) begin
                            state_q <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (boundary) begin
                            state_q <= S_DONE;
                            cs_n_q  <= '1;
                            done_q  <= 1'b1;
                            rdata_q <= rx_q;
                            mosi_q  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign cs_n  = cs_n_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: directed transactions, scoreboard checked on each done pulse.
`timescale 1ns/1ps
module tb_spi_burst_master;

    // NUM_CS=5 so that cs_sel is wide enough to carry an out-of-range target.
    localparam int NCS = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  cs_sel = '0;
    logic [2:0]  num_bytes = '0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [7:0]  clk_div = '0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic [NCS-1:0] cs_n;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        inv_miso = 1'b0;

    assign miso = inv_miso ? ~mosi : mosi;

    spi_burst_master #(
        .ADDR_WIDTH (8),
        .MAX_BYTES  (4),
        .NUM_CS     (NCS),
        .DIV_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .cs_sel    (cs_sel),
        .num_bytes (num_bytes),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
        .addr      (addr),
        .wdata     (wdata),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    int     done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          lat;
        longint      t0;
    } exp_t;
    exp_t exp_q[$];

    // Scoreboard monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rstn && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_rdata"}, 64'(rdata), 64'(e.rdata));
                check({e.name, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    // sclk monitor: rising edges, narrowest half-period, mosi at each sampling edge.
    logic        mon_en = 1'b0;
    logic        cur_cpol = 1'b0;
    logic        cur_cpha = 1'b0;
    int          rise_cnt;
    int          cap_n;
    logic [63:0] cap;
    time         last_t;
    time         min_w;

    always @(sclk) begin
        if (mon_en) begin
            if ($time - last_t < min_w) min_w = $time - last_t;
            last_t = $time;
            if (sclk === 1'b1) rise_cnt++;
            if ((sclk !== cur_cpol) != cur_cpha) begin
                cap = {cap[62:0], mosi};
                cap_n++;
            end
        end
    end

    task automatic run_txn(input string name, input logic p_cpol, input logic p_cpha,
                           input logic [7:0] p_div, input logic [2:0] p_cs, input logic [2:0] p_nb,
                           input logic [7:0] p_addr, input logic [31:0] p_wdata, input logic p_inv,
                           input logic [31:0] e_rdata, input int e_n, input int e_lat,
                           input logic [NCS-1:0] e_cs_n, input logic [63:0] e_stream);
        bit got_done;
        @(negedge clk);
        cpol = p_cpol; cpha = p_cpha; clk_div = p_div; cs_sel = p_cs;
        num_bytes = p_nb; addr = p_addr; wdata = p_wdata; inv_miso = p_inv;
        cur_cpol = p_cpol; cur_cpha = p_cpha;
        repeat (2) @(negedge clk);
        check({name, "_idle_sclk"}, 64'(sclk), 64'(p_cpol));
        rise_cnt = 0; cap_n = 0; cap = '0; last_t = $time; min_w = 64'd1000000; mon_en = 1'b1;
        exp_q.push_back('{name, e_rdata, e_lat, cyc});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs are latched at acceptance; disturbing them now must not matter.
        addr = ~p_addr; wdata = ~p_wdata; num_bytes = 3'd0; clk_div = 8'd9; cpha = ~p_cpha; cs_sel = 3'd0;
        check({name, "_busy_setup"}, 64'(busy), 64'd1);
        check({name, "_cs_n_active"}, 64'(cs_n), 64'(e_cs_n));
        got_done = 1'b0;
        for (int i = 0; i < e_lat + 10; i++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, 64'(got_done), 64'd1);
        @(negedge clk);
        mon_en = 1'b0;
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_cs_n_after"}, 64'(cs_n), 64'h1F);
        check({name, "_sclk_after"}, 64'(sclk), 64'(p_cpol));
        check({name, "_mosi_stream"}, cap, e_stream);
        check({name, "_bits"}, 64'(cap_n), 64'(e_n));
        check({name, "_rises"}, 64'(rise_cnt), 64'(e_n));
        check({name, "_min_half"}, 64'(min_w >= 10 * (64'(p_div) + 1)), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        bit saw_busy;
        repeat (3) @(negedge clk);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_cs_n", 64'(cs_n), 64'h1F);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_flags", {61'd0, busy, done, err}, 64'd0);
        rstn = 1'b1;

        //       name    cpol cpha div cs  nb  addr   wdata          inv rdata          N   lat  cs_n      stream
        run_txn("m0",    0,   0,   0,  0,  1,  8'hA5, 32'h0000003C,  1,  32'h000000C3,  16, 35,  5'b11110, 64'hA53C);
        run_txn("m1",    0,   1,   3,  1,  2,  8'h5A, 32'h0000BEEF,  0,  32'h0000BEEF,  24, 201, 5'b11101, 64'h5ABEEF);
        run_txn("m2",    1,   0,   3,  2,  2,  8'h5A, 32'h0000BEEF,  0,  32'h0000BEEF,  24, 201, 5'b11011, 64'h5ABEEF);
        run_txn("m3",    1,   1,   3,  3,  2,  8'h5A, 32'h0000BEEF,  0,  32'h0000BEEF,  24, 201, 5'b10111, 64'h5ABEEF);
        run_txn("nb0",   0,   0,   2,  0,  0,  8'h81, 32'hFFFFFFFF,  0,  32'h00000000,  8,  55,  5'b11110, 64'h81);
        run_txn("nb7",   0,   0,   0,  4,  7,  8'hC3, 32'h12345678,  0,  32'h12345678,  40, 83,  5'b01111, 64'hC312345678);

        // Abort in the data phase, with a start pulse issued while busy.
        @(negedge clk);
        cpol = 0; cpha = 0; clk_div = 8'd1; cs_sel = 3'd0; num_bytes = 3'd2;
        addr = 8'h11; wdata = 32'h2233; inv_miso = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cs_n", 64'(cs_n), 64'h1F);
        check("abort_sclk", 64'(sclk), 64'd0);
        check("abort_mosi", 64'(mosi), 64'd0);
        saw_busy = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("abort_no_restart", 64'(saw_busy), 64'd0);
        check("abort_no_done", 64'(done_cnt), 64'd6);
        check("abort_rdata_kept", 64'(rdata), 64'h12345678);

        // Out-of-range chip select.
        cs_sel = 3'd5; num_bytes = 3'd1; inv_miso = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 64'(err), 64'd1);
        check("err_cs_n", 64'(cs_n), 64'h1F);
        check("err_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("err_one_cycle", 64'(err), 64'd0);
        saw_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("err_no_txn", 64'(saw_busy), 64'd0);
        check("err_no_done", 64'(done_cnt), 64'd6);

        // Asynchronous reset in the middle of SHIFT.
        cpol = 1; cpha = 0; clk_div = 8'd0; cs_sel = 3'd1; num_bytes = 3'd1;
        addr = 8'hF0; wdata = 32'h55;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("rstmid_busy_before", 64'(busy), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("rstmid_sclk", 64'(sclk), 64'd0);
        check("rstmid_mosi", 64'(mosi), 64'd0);
        check("rstmid_cs_n", 64'(cs_n), 64'h1F);
        check("rstmid_rdata", 64'(rdata), 64'd0);
        check("rstmid_flags", {61'd0, busy, done, err}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_txn("post_rst", 0, 1, 1, 2, 3, 8'h3E, 32'hFFABCDEF, 0, 32'h00ABCDEF, 32, 133, 5'b11011, 64'h3EABCDEF);

        repeat (5) @(negedge clk);
        check("total_dones", 64'(done_cnt), 64'd7);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
